// File: rtl/l1_access_ctrl.sv
// Two-port front end for the direct-mapped L1: round-robin request arbitration,
// tag lookup, single-outstanding L2 refill, one-cycle response and hit/miss stats.
module l1_access_ctrl #(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              resp_valid,
  output logic              resp_port,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_data,
  output logic              l2_req_valid,
  output logic [ADDR_W-1:0] l2_req_addr,
  input  logic              l2_req_ready,
  input  logic              l2_resp_valid,
  input  logic [DATA_W-1:0] l2_resp_data,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int unsigned OFF_W = 4;
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, L2_REQ, L2_WAIT, RESP} state_t;

  state_t               state;
  state_t               next_state;
  logic [ADDR_W-1:0]    lat_addr;
  logic                 lat_port;
  logic                 last_grant;
  logic [NUM_LINES-1:0] line_valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [DATA_W-1:0]    data_mem [NUM_LINES];

  logic                 grant;
  logic                 grant_port;
  logic [IDX_W-1:0]     lat_idx;
  logic [TAG_W-1:0]     lat_tag;
  logic                 lookup_hit;
  logic                 refill;
  logic                 unused_offset;

  assign lat_idx       = lat_addr[OFF_W +: IDX_W];
  assign lat_tag       = lat_addr[OFF_W+IDX_W +: TAG_W];
  assign lookup_hit    = line_valid[lat_idx] && (tag_mem[lat_idx] == lat_tag);
  assign refill        = (state == L2_WAIT) && l2_resp_valid;
  assign unused_offset = ^lat_addr[OFF_W-1:0];

  // Next state, arbitration and the combinational accept strobes
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && !flush && (req0_valid || req1_valid)) begin
          grant      = 1'b1;
          grant_port = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
          next_state = LOOKUP;
        end
        req0_ready = grant && !grant_port;
        req1_ready = grant && grant_port;
      end
      LOOKUP:  next_state = lookup_hit ? RESP : L2_REQ;
      L2_REQ:  if (l2_req_ready) next_state = L2_WAIT;
      L2_WAIT: if (l2_resp_valid) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_addr     <= '0;
      lat_port     <= 1'b0;
      last_grant   <= 1'b1;
      line_valid   <= '0;
      resp_valid   <= 1'b0;
      resp_port    <= 1'b0;
      resp_hit     <= 1'b0;
      resp_data    <= '0;
      l2_req_valid <= 1'b0;
      l2_req_addr  <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      state        <= next_state;
      resp_valid   <= (next_state == RESP);
      l2_req_valid <= (next_state == L2_REQ);
      if (grant) begin
        lat_addr   <= grant_port ? req1_addr : req0_addr;
        lat_port   <= grant_port;
        last_grant <= grant_port;
      end
      if ((state == IDLE) && flush) begin
        line_valid <= '0;
      end
      if (state == LOOKUP) begin
        resp_port <= lat_port;
        if (lookup_hit) begin
          resp_hit  <= 1'b1;
          resp_data <= data_mem[lat_idx];
          if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
        end else begin
          l2_req_addr <= {lat_tag, lat_idx, OFF_W'(0)};
          if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
        end
      end
      if (refill) begin
        line_valid[lat_idx] <= 1'b1;
        resp_hit            <= 1'b0;
        resp_data           <= l2_resp_data;
      end
    end
  end

  // Tag/data arrays carry no reset; a refill racing a reset is dropped
  always_ff @(posedge clk) begin
    if (refill && !rst) begin
      tag_mem[lat_idx]  <= lat_tag;
      data_mem[lat_idx] <= l2_resp_data;
    end
  end

endmodule

// File: tb/tb_l1_access_ctrl.sv
// Directed + randomized bench for l1_access_ctrl against a line-level cache model;
// a second instance with 2-bit counters exercises counter saturation.
module tb_l1_access_ctrl;
  logic        clk;
  logic        rst;
  logic        flush;
  logic        req0_valid, req1_valid;
  logic [10:0] req0_addr, req1_addr;
  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_port, resp_hit;
  logic [31:0] resp_data;
  logic        l2_req_valid;
  logic [10:0] l2_req_addr;
  logic        l2_req_ready;
  logic        l2_resp_valid;
  logic [31:0] l2_resp_data;
  logic [15:0] hit_count, miss_count;

  logic        s_req0_ready, s_req1_ready, s_resp_valid, s_resp_port, s_resp_hit;
  logic [31:0] s_resp_data;
  logic        s_l2_req_valid;
  logic [10:0] s_l2_req_addr;
  logic [1:0]  s_hit_count, s_miss_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: cache contents, arbitration pointer and counts
  bit          m_valid [16];
  logic [2:0]  m_tag   [16];
  logic [31:0] m_data  [16];
  int          m_last  = 1;
  int          m_hits  = 0;
  int          m_miss  = 0;
  int          last_acc, last_resp;

  l1_access_ctrl u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_port(resp_port), .resp_hit(resp_hit), .resp_data(resp_data),
    .l2_req_valid(l2_req_valid), .l2_req_addr(l2_req_addr), .l2_req_ready(l2_req_ready),
    .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  l1_access_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(s_req1_ready),
    .resp_valid(s_resp_valid), .resp_port(s_resp_port), .resp_hit(s_resp_hit), .resp_data(s_resp_data),
    .l2_req_valid(s_l2_req_valid), .l2_req_addr(s_l2_req_addr), .l2_req_ready(l2_req_ready),
    .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Never both readies at once; resp_valid is a single-cycle pulse
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    #1;
    if (req0_ready || req1_ready) chk("single_ready", {req0_ready, req1_ready} == 2'b11, 1'b0);
    if (resp_valid) chk("resp_pulse", prev_rv, 1'b0);
    prev_rv = resp_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish (tests=%0d)", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic wait_grant(output int g, output int t);
    g = -1;
    t = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req0_ready || req1_ready) begin
        g = req1_ready ? 1 : 0;
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (g < 0) chk("grant_timeout", req0_ready | req1_ready, 1'b1);
  endtask

  // Accept one request from the currently driven valids and follow it to its response
  task automatic run_txn(input int rdy_dly, input int rsp_dly, input logic [31:0] fill, input bit keep);
    int g, t_acc, exp_g, t_rv, wcnt;
    logic [10:0] a;
    logic [3:0] ix;
    logic [31:0] exp_data;
    bit exp_hit, got, hs, rv_sent, first;
    exp_g = (req0_valid && req1_valid) ? (1 - m_last) : (req0_valid ? 0 : 1);
    wait_grant(g, t_acc);
    if (g < 0) return;
    chk("grant_port", 64'(g), 64'(exp_g));
    m_last   = g;
    last_acc = t_acc;
    a        = g ? req1_addr : req0_addr;
    ix       = a[7:4];
    exp_hit  = m_valid[ix] && (m_tag[ix] == a[10:8]);
    exp_data = m_data[ix];
    @(negedge clk);
    chk("ready_busy", {req0_ready, req1_ready}, 2'b00);
    if (!keep) begin
      if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    end
    got = 0; hs = 0; rv_sent = 0; first = 1; wcnt = 0; t_rv = -1000;
    for (int k = 0; k < 80 && !got; k++) begin
      @(negedge clk);
      l2_req_ready  = 1'b0;
      l2_resp_valid = 1'b0;
      l2_resp_data  = $urandom;
      if (resp_valid) begin
        got = 1;
      end else if (l2_req_valid && !hs) begin
        if (first) begin
          chk("l2_req_start", 64'(cyc - t_acc), 64'd2);
          chk("l2_req_addr", l2_req_addr, {a[10:4], 4'h0});
          first = 0;
        end
        if (wcnt >= rdy_dly) begin
          chk("l2_addr_stable", l2_req_addr, {a[10:4], 4'h0});
          l2_req_ready = 1'b1;
          hs = 1;
          wcnt = 0;
        end else wcnt++;
      end else if (hs && !rv_sent) begin
        if (wcnt >= rsp_dly) begin
          l2_resp_valid = 1'b1;
          l2_resp_data  = fill;
          t_rv    = cyc;
          rv_sent = 1;
        end else wcnt++;
      end
    end
    if (!got) begin
      chk("resp_timeout", resp_valid, 1'b1);
      return;
    end
    last_resp = cyc;
    chk("resp_port", resp_port, 64'(g));
    chk("resp_hit", resp_hit, exp_hit);
    if (exp_hit) begin
      chk("hit_latency", 64'(cyc - t_acc), 64'd2);
      chk("hit_data", resp_data, exp_data);
      m_hits++;
    end else begin
      chk("miss_latency", 64'(cyc - t_rv), 64'd1);
      chk("miss_data", resp_data, fill);
      m_miss++;
      m_valid[ix] = 1'b1;
      m_tag[ix]   = a[10:8];
      m_data[ix]  = fill;
    end
    chk("hit_count", hit_count, 64'(sat(m_hits, 16)));
    chk("miss_count", miss_count, 64'(sat(m_miss, 16)));
    chk("sat_hit_count", s_hit_count, 64'(sat(m_hits, 2)));
    chk("sat_miss_count", s_miss_count, 64'(sat(m_miss, 2)));
  endtask

  initial begin
    int g, t, t_f, prev;
    bit any_resp;
    rst = 1'b1; flush = 1'b0;
    req0_valid = 1'b1; req0_addr = 11'h123;
    req1_valid = 1'b0; req1_addr = '0;
    l2_req_ready = 1'b0; l2_resp_valid = 1'b0; l2_resp_data = '0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_l2_req_valid", l2_req_valid, 1'b0);
    chk("rst_l2_req_addr", l2_req_addr, 11'h0);
    chk("rst_hit_count", hit_count, 16'h0);
    chk("rst_miss_count", miss_count, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // cold miss then hit on the same line
    run_txn(0, 1, 32'hCAFEF00D, 0);
    req0_addr = 11'h12C; req0_valid = 1'b1;
    run_txn(0, 0, 32'h0, 0);

    // conflict eviction on index 2
    req1_addr = 11'h520; req1_valid = 1'b1;
    run_txn(2, 1, 32'h5555AAAA, 0);
    req0_addr = 11'h120; req0_valid = 1'b1;
    run_txn(1, 3, 32'h1234ABCD, 0);

    // leave last grant at port 1, then hold both ports for four transactions
    req1_addr = 11'h000; req1_valid = 1'b1;
    run_txn(0, 0, 32'h00C0FFEE, 0);
    req0_addr = 11'h040; req1_addr = 11'h080;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prev = last_resp;
      run_txn(0, 0, 32'hA0000000 + 32'(i), 1);
      chk("b2b_grant", 64'(last_acc - prev), 64'd1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // flush coinciding with a request to a cached line
    @(negedge clk);
    req0_addr = 11'h040; req0_valid = 1'b1; flush = 1'b1;
    #1 chk("flush_blocks_grant", req0_ready, 1'b0);
    t_f = cyc;
    @(negedge clk);
    flush = 1'b0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    run_txn(0, 0, 32'hF1F1F1F1, 0);
    chk("grant_after_flush", 64'(last_acc - t_f), 64'd1);

    // randomized single-port traffic over a small address footprint
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        req0_addr = {3'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)};
        req0_valid = 1'b1;
      end else begin
        req1_addr = {3'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)};
        req1_valid = 1'b1;
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 0);
    end

    // reset while waiting for L2, followed by a late refill strobe
    @(negedge clk);
    req0_addr = 11'h7A0; req0_valid = 1'b1;
    wait_grant(g, t);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_l2_req", l2_req_valid, 1'b1);
    l2_req_ready = 1'b1;
    @(negedge clk);
    l2_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    l2_resp_valid = 1'b1; l2_resp_data = 32'h0BAD0BAD;
    chk("mid_rst_l2_req_valid", l2_req_valid, 1'b0);
    chk("mid_rst_l2_req_addr", l2_req_addr, 11'h0);
    chk("mid_rst_hit_count", hit_count, 16'h0);
    chk("mid_rst_miss_count", miss_count, 16'h0);
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_last = 1; m_hits = 0; m_miss = 0;
    any_resp = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      l2_resp_valid = 1'b0;
      if (resp_valid) any_resp = 1'b1;
    end
    chk("no_resp_after_rst", any_resp, 1'b0);
    req0_addr = 11'h7A4; req0_valid = 1'b1;
    run_txn(0, 0, 32'h77777777, 0);
    req0_addr = 11'h7A8; req0_valid = 1'b1;
    run_txn(0, 0, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
